fifo_uart_tx: RTL and testbench

UART 8N1/8N2 transmitter on the read side of the 8-deep byte FIFO. It pops bytes through the FIFO's first-word-fall-through interface: read data is valid whenever the FIFO is not empty, and a pop takes effect at the clock edge. Each byte is serialised LSB-first on the tx line. Consecutive bytes go out back-to-back with no idle gap, so a burst written into the FIFO by the receive or counter path streams out at full baud rate.

---
 rtl/fifo_uart_tx.sv | 131 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: UART 8N1/8N2 transmitter fed from a first-word-fall-through byte FIFO.
// Bytes are popped whenever the line is free (idle, or the last stop-bit cycle) and
// shifted out LSB-first, so queued bytes stream back-to-back with no idle gap.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   tx_en       transmit enable; only gates the start of a new frame
//   fifo_empty  FIFO empty flag
//   fifo_rdata  FIFO head byte, valid while fifo_empty=0
//   fifo_rd     FIFO pop strobe (combinational), one cycle per byte
//   tx          registered serial line, idle high
//   tx_busy     high while a frame is on the line
//   tx_done     one-cycle pulse on the final cycle of each frame
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_rdata,
    output logic       fifo_rd,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int unsigned     BaudW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       StopLast = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e           state_q, state_d;
    logic [BaudW-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_end;
    logic             stop_last;
    logic             pop;

    assign bit_end   = (baud_q == BaudMax);
    // In STOP, bit_q counts stop bits so the 2-stop-bit case reuses the same counter.
    assign stop_last = (state_q == StStop) && bit_end && (bit_q == StopLast);
    // Gated by rst so no byte is popped (and lost) while the block is held in reset.
    assign pop       = tx_en & ~fifo_empty & ~rst & ((state_q == StIdle) | stop_last);

    assign fifo_rd = pop;
    assign tx      = tx_q;
    assign tx_busy = (state_q != StIdle);
    assign tx_done = stop_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = bit_end ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        unique case (state_q)
            StIdle: begin
                baud_d = '0;
                if (pop) begin
                    state_d = StStart;
                    shift_d = fifo_rdata;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        // Next data bit is bit 1 of the pre-shift register.
                        tx_d  = shift_q[1];
                    end
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (bit_q == StopLast) begin
                        bit_d = '0;
                        if (pop) begin
                            state_d = StStart;
                            shift_d = fifo_rdata;
                            tx_d    = 1'b0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: self-checking bench for fifo_uart_tx.
// A queue models the FWFT FIFO; a frame-level reference model (countdown of cycles
// left in the current frame) predicts tx/fifo_rd/tx_busy/tx_done every cycle.
// A second instance with STOP_BITS=2 covers the two-stop-bit frame.
module tb_fifo_uart_tx;

    localparam int C  = 4;
    localparam int L  = 10 * C;
    localparam int L2 = 11 * C;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_rd, tx, tx_busy, tx_done;

    logic       tx_en2;
    logic       fifo_empty2;
    logic [7:0] fifo_rdata2;
    logic       fifo_rd2, tx2, tx_busy2, tx_done2;

    int total = 0;
    int bad   = 0;

    logic [7:0] fq[$];
    int         rem = 0;
    logic [7:0] cur;
    // Per-cycle packed samples {tx, fifo_rd, tx_busy, tx_done}.
    logic [3:0] o_log[$];
    logic [3:0] e_log[$];

    fifo_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    fifo_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .tx_en      (tx_en2),
        .fifo_empty (fifo_empty2),
        .fifo_rdata (fifo_rdata2),
        .fifo_rd    (fifo_rd2),
        .tx         (tx2),
        .tx_busy    (tx_busy2),
        .tx_done    (tx_done2)
    );

    always #5 clk = ~clk;

    // Line level at cycle k (0-based) of a frame: start, 8 data bits LSB-first, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k, input int c);
        int n;
        n = k / c;
        if (n == 0) return 1'b0;
        else if (n <= 8) return b[n-1];
        else return 1'b1;
    endfunction

    task automatic drive_fifo();
        fifo_empty = (fq.size() == 0);
        fifo_rdata = (fq.size() != 0) ? fq[0] : 8'($urandom);
    endtask

    task automatic clear_logs();
        o_log.delete();
        e_log.delete();
    endtask

    // One clock: sample + predict at negedge, apply the FIFO pop just after posedge.
    task automatic tick();
        logic popped;
        logic ev_rd;
        @(negedge clk);
        o_log.push_back({tx, fifo_rd, tx_busy, tx_done});
        if (rst) begin
            rem = 0;
            e_log.push_back(4'b1000);
        end else begin
            ev_rd = tx_en && (fq.size() > 0) && (rem <= 1);
            e_log.push_back({(rem > 0) ? frame_bit(cur, L - rem, C) : 1'b1,
                             ev_rd, rem > 0, rem == 1});
            if (ev_rd) begin
                cur = fq[0];
                rem = L;
            end else if (rem > 0) begin
                rem--;
            end
        end
        popped = fifo_rd;
        @(posedge clk);
        #1;
        if (popped === 1'b1 && fq.size() > 0) void'(fq.pop_front());
        drive_fifo();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        tx_en  = 1'b1;
        tx_en2 = 1'b1;
        fifo_empty2 = 1'b1;
        fifo_rdata2 = 8'h00;
        drive_fifo();
        #1;
        total++;
        if ({tx, fifo_rd, tx_busy, tx_done} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_async got %b want 1000", {tx, fifo_rd, tx_busy, tx_done});
        end
        clear_logs();
        run(5);
        rst = 1'b0;
        run(100);
        for (int i = 0; i < o_log.size(); i++) begin
            total++;
            if (o_log[i] !== e_log[i]) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d {tx,rd,busy,done} got %b want %b",
                         i, o_log[i], e_log[i]);
            end
        end
    endtask

    task automatic test_single();
        logic [9:0] pat;
        int p;
        int rd_cnt;
        pat = 10'b11_0100_1010;
        tx_en = 1'b1;
        clear_logs();
        fq.push_back(8'hA5);
        drive_fifo();
        run(45);
        for (int i = 0; i < o_log.size(); i++) begin
            total++;
            if (o_log[i] !== e_log[i]) begin
                bad++;
                $display("FAIL single cyc=%0d {tx,rd,busy,done} got %b want %b",
                         i, o_log[i], e_log[i]);
            end
        end
        p = -1;
        rd_cnt = 0;
        for (int i = 0; i < o_log.size(); i++) begin
            if (o_log[i][2] === 1'b1) begin
                rd_cnt++;
                if (p < 0) p = i;
            end
        end
        total++;
        if (rd_cnt != 1 || p < 0 || p + 41 >= o_log.size()) begin
            bad++;
            $display("FAIL single_pop count got %0d want 1 (first at %0d)", rd_cnt, p);
        end else begin
            for (int k = 0; k < L; k++) begin
                total++;
                if (o_log[p+1+k][3] !== pat[k/C]) begin
                    bad++;
                    $display("FAIL single_bits k=%0d got %b want %b", k, o_log[p+1+k][3],
                             pat[k/C]);
                end
            end
            total++;
            if (o_log[p+L][0] !== 1'b1 || o_log[p+L+1][1] !== 1'b0) begin
                bad++;
                $display("FAIL single_end done got %b busy_after got %b want 1 and 0",
                         o_log[p+L][0], o_log[p+L+1][1]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pops[$];
        int busy_cnt;
        int done_cnt;
        tx_en = 1'b1;
        clear_logs();
        fq.push_back(8'h55);
        fq.push_back(8'h0F);
        drive_fifo();
        run(90);
        for (int i = 0; i < o_log.size(); i++) begin
            total++;
            if (o_log[i] !== e_log[i]) begin
                bad++;
                $display("FAIL b2b cyc=%0d {tx,rd,busy,done} got %b want %b",
                         i, o_log[i], e_log[i]);
            end
        end
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < o_log.size(); i++) begin
            if (o_log[i][2] === 1'b1) pops.push_back(i);
            if (o_log[i][1] === 1'b1) busy_cnt++;
            if (o_log[i][0] === 1'b1) done_cnt++;
        end
        total++;
        if (pops.size() != 2 || pops[1] - pops[0] != L) begin
            bad++;
            $display("FAIL b2b_pops count got %0d want 2 (spacing must be %0d)", pops.size(), L);
        end
        total++;
        if (busy_cnt != 2 * L || done_cnt != 2) begin
            bad++;
            $display("FAIL b2b_busy busy got %0d want %0d, done got %0d want 2",
                     busy_cnt, 2 * L, done_cnt);
        end
    endtask

    task automatic test_tx_en_gate();
        int rd_cnt;
        tx_en = 1'b0;
        clear_logs();
        fq.push_back(8'($urandom));
        drive_fifo();
        run(50);
        rd_cnt = 0;
        for (int i = 0; i < o_log.size(); i++) if (o_log[i][2] === 1'b1) rd_cnt++;
        total++;
        if (rd_cnt != 0) begin
            bad++;
            $display("FAIL en_gate_hold pops got %0d want 0", rd_cnt);
        end
        tx_en = 1'b1;
        #1;
        total++;
        if (fifo_rd !== 1'b1) begin
            bad++;
            $display("FAIL en_gate_rd got %b want 1", fifo_rd);
        end
        run(45);
        for (int i = 0; i < o_log.size(); i++) begin
            total++;
            if (o_log[i] !== e_log[i]) begin
                bad++;
                $display("FAIL en_gate cyc=%0d {tx,rd,busy,done} got %b want %b",
                         i, o_log[i], e_log[i]);
            end
        end
    endtask

    task automatic test_en_drop();
        logic [7:0] b[3];
        int rd_cnt;
        tx_en = 1'b1;
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            b[i] = 8'($urandom);
            fq.push_back(b[i]);
        end
        drive_fifo();
        run(15);
        tx_en = 1'b0;
        run(60);
        rd_cnt = 0;
        for (int i = 0; i < o_log.size(); i++) if (o_log[i][2] === 1'b1) rd_cnt++;
        total++;
        if (rd_cnt != 1 || fq.size() != 2) begin
            bad++;
            $display("FAIL en_drop_hold pops got %0d want 1, queued got %0d want 2",
                     rd_cnt, fq.size());
        end else begin
            total++;
            if (fq[0] !== b[1] || fq[1] !== b[2]) begin
                bad++;
                $display("FAIL en_drop_queue got %h %h want %h %h", fq[0], fq[1], b[1], b[2]);
            end
        end
        tx_en = 1'b1;
        run(90);
        for (int i = 0; i < o_log.size(); i++) begin
            total++;
            if (o_log[i] !== e_log[i]) begin
                bad++;
                $display("FAIL en_drop cyc=%0d {tx,rd,busy,done} got %b want %b",
                         i, o_log[i], e_log[i]);
            end
        end
        total++;
        if (fq.size() != 0) begin
            bad++;
            $display("FAIL en_drop_drain queued got %0d want 0", fq.size());
        end
    endtask

    task automatic test_async_reset();
        int rd_cnt;
        tx_en = 1'b1;
        clear_logs();
        fq.push_back(8'($urandom));
        drive_fifo();
        run(20);
        #1;
        rst = 1'b1;
        #1;
        total++;
        if ({tx, tx_busy, tx_done} !== 3'b100) begin
            bad++;
            $display("FAIL areset_now {tx,busy,done} got %b want 100", {tx, tx_busy, tx_done});
        end
        rem = 0;
        fq.push_back(8'($urandom));
        drive_fifo();
        #1;
        total++;
        if (fifo_rd !== 1'b0) begin
            bad++;
            $display("FAIL areset_rd got %b want 0", fifo_rd);
        end
        clear_logs();
        tick();
        rst = 1'b0;
        run(45);
        rd_cnt = 0;
        for (int i = 0; i < o_log.size(); i++) begin
            if (o_log[i][2] === 1'b1) rd_cnt++;
            total++;
            if (o_log[i] !== e_log[i]) begin
                bad++;
                $display("FAIL areset cyc=%0d {tx,rd,busy,done} got %b want %b",
                         i, o_log[i], e_log[i]);
            end
        end
        total++;
        if (rd_cnt != 1) begin
            bad++;
            $display("FAIL areset_pops got %0d want 1", rd_cnt);
        end
    endtask

    task automatic test_random();
        clear_logs();
        for (int r = 0; r < 12; r++) begin
            for (int j = $urandom_range(0, 3); j > 0; j--) fq.push_back(8'($urandom));
            tx_en = ($urandom_range(0, 3) != 0);
            drive_fifo();
            run($urandom_range(5, 70));
        end
        tx_en = 1'b1;
        run(8 * L);
        for (int i = 0; i < o_log.size(); i++) begin
            total++;
            if (o_log[i] !== e_log[i]) begin
                bad++;
                $display("FAIL random cyc=%0d {tx,rd,busy,done} got %b want %b",
                         i, o_log[i], e_log[i]);
            end
        end
    endtask

    task automatic test_stop2();
        logic [3:0] q2[$];
        logic [3:0] ev;
        logic       popped;
        int p;
        int rd_cnt;
        tx_en2      = 1'b1;
        fifo_empty2 = 1'b0;
        fifo_rdata2 = 8'h00;
        for (int i = 0; i < L2 + 8; i++) begin
            @(negedge clk);
            q2.push_back({tx2, fifo_rd2, tx_busy2, tx_done2});
            popped = fifo_rd2;
            @(posedge clk);
            #1;
            if (popped === 1'b1) begin
                fifo_empty2 = 1'b1;
                fifo_rdata2 = 8'($urandom_range(1, 255));
            end
        end
        p = -1;
        rd_cnt = 0;
        for (int i = 0; i < q2.size(); i++) begin
            if (q2[i][2] === 1'b1) begin
                rd_cnt++;
                if (p < 0) p = i;
            end
        end
        total++;
        if (rd_cnt != 1 || p < 0 || p + L2 + 1 >= q2.size()) begin
            bad++;
            $display("FAIL stop2_pop count got %0d want 1 (first at %0d)", rd_cnt, p);
        end else begin
            for (int k = 0; k < L2; k++) begin
                ev = {frame_bit(8'h00, k, C), 1'b0, 1'b1, k == L2 - 1};
                total++;
                if (q2[p+1+k] !== ev) begin
                    bad++;
                    $display("FAIL stop2 k=%0d {tx,rd,busy,done} got %b want %b",
                             k, q2[p+1+k], ev);
                end
            end
            total++;
            if (q2[p+L2+1] !== 4'b1000) begin
                bad++;
                $display("FAIL stop2_idle got %b want 1000", q2[p+L2+1]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_tx_en_gate();
        test_en_drop();
        test_async_reset();
        test_random();
        test_stop2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
